// File: rtl/l2_rr_arbiter_pkg.sv
// Shared L2 configuration and types.
//   L2_NUM_PORTS : default number of requesting L2 ports
//   arb_state_t  : round-robin arbiter state (idle / holding a grant)
package l2_config_and_types;

    localparam int L2_NUM_PORTS = 4;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/l2_rr_arbiter_if.sv
// L2 arbitration interface between the L2 front-end (master) and the
// round-robin arbiter (slave).
//   requests      : per-port request vector, driven by master
//   strobe        : master accepts the presented grant this cycle
//   grantee_i     : granted port index, driven by slave
//   grantee_v     : one-hot granted port, driven by slave
//   grantee_valid : grantee_i / grantee_v are meaningful, driven by slave
interface l2_rr_arbiter_if
    import l2_config_and_types::*;
#(
    parameter int NUM_PORTS = L2_NUM_PORTS
) ();

    localparam int IW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] requests;
    logic                 strobe;
    logic [IW-1:0]        grantee_i;
    logic [NUM_PORTS-1:0] grantee_v;
    logic                 grantee_valid;

    modport master (
        output requests, strobe,
        input  grantee_i, grantee_v, grantee_valid
    );

    modport slave (
        input  requests, strobe,
        output grantee_i, grantee_v, grantee_valid
    );

endinterface

// File: rtl/l2_rr_arbiter_picker.sv
// Combinational round-robin picker.
//   requests    : per-port request vector
//   last_ptr    : index of the last accepted grantee
//   pick_idx    : first requesting port at or after last_ptr+1 (with wrap)
//   pick_onehot : one-hot of pick_idx, zero when nothing requests
//   any         : at least one port requests
module l2_rr_picker
    import l2_config_and_types::*;
#(
    parameter int NUM_PORTS = L2_NUM_PORTS,
    localparam int IW = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] requests,
    input  logic [IW-1:0]        last_ptr,
    output logic [IW-1:0]        pick_idx,
    output logic [NUM_PORTS-1:0] pick_onehot,
    output logic                 any
);

    localparam int unsigned NP = NUM_PORTS;

    logic [2*NUM_PORTS-1:0] dbl;
    logic [2*NUM_PORTS-1:0] masked;
    int unsigned            start;

    // The request vector is duplicated and bits below the start position are
    // masked off, so a plain low-to-high priority search over the doubled
    // vector wraps correctly for any port count, including non-powers of two.
    always_comb begin
        start = 32'(last_ptr) + 32'd1;
        if (start >= NP) begin
            start = 0;
        end
        dbl    = {requests, requests};
        masked = '0;
        for (int unsigned i = 0; i < 2 * NP; i++) begin
            masked[i] = dbl[i] && (i >= start);
        end

        any         = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int unsigned i = 0; i < 2 * NP; i++) begin
            if (!any && masked[i]) begin
                any      = 1'b1;
                pick_idx = IW'((i >= NP) ? (i - NP) : i);
            end
        end
        if (any) begin
            pick_onehot[pick_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/l2_rr_arbiter.sv
// Round-robin arbiter for the L2 request ports (slave side of the L2
// arbitration interface). Presents a grant combinationally and holds it
// until the master strobes acceptance.
//   clk : clock
//   rst : asynchronous active-high reset
//   arb : arbitration interface, slave modport
module l2_rr_arbiter
    import l2_config_and_types::*;
#(
    parameter int NUM_PORTS = L2_NUM_PORTS
) (
    input  logic                clk,
    input  logic                rst,
    l2_rr_arbiter_if.slave      arb
);

    localparam int IW = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2) begin : g_param_check
        $error("l2_rr_arbiter: NUM_PORTS must be at least 2");
    end

    arb_state_t           state;
    logic [IW-1:0]        last_ptr;
    logic [IW-1:0]        lock_idx;
    logic [IW-1:0]        pick_idx;
    logic [NUM_PORTS-1:0] pick_onehot;
    logic                 pick_any;
    logic                 lock_valid;

    l2_rr_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .requests    (arb.requests),
        .last_ptr    (last_ptr),
        .pick_idx    (pick_idx),
        .pick_onehot (pick_onehot),
        .any         (pick_any)
    );

    assign lock_valid = arb.requests[lock_idx];

    always_comb begin
        arb.grantee_i     = '0;
        arb.grantee_v     = '0;
        arb.grantee_valid = 1'b0;
        if (state == ARB_LOCKED) begin
            arb.grantee_i           = lock_idx;
            arb.grantee_v[lock_idx] = 1'b1;
            arb.grantee_valid       = lock_valid;
        end else begin
            arb.grantee_i     = pick_idx;
            arb.grantee_v     = pick_onehot;
            arb.grantee_valid = pick_any;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            last_ptr <= IW'(NUM_PORTS - 1);
            lock_idx <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        if (arb.strobe) begin
                            last_ptr <= pick_idx;
                        end else begin
                            lock_idx <= pick_idx;
                            state    <= ARB_LOCKED;
                        end
                    end
                end
                ARB_LOCKED: begin
                    // A withdrawn request drops the lock without advancing
                    // last_ptr; any strobe in that cycle is ignored.
                    if (!lock_valid) begin
                        state <= ARB_IDLE;
                    end else if (arb.strobe) begin
                        last_ptr <= lock_idx;
                        state    <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(arb.grantee_v));

    a_valid_has_request : assert property (@(posedge clk) disable iff (rst)
        arb.grantee_valid |-> arb.requests[arb.grantee_i]);

    a_lock_stable : assert property (@(posedge clk) disable iff (rst)
        (state == ARB_LOCKED && !arb.strobe) |-> $stable(arb.grantee_i));

    a_no_withdraw : assert property (@(posedge clk) disable iff (rst)
        (state == ARB_LOCKED) |-> lock_valid)
        else $warning("l2_rr_arbiter: port %0d withdrew its request while its grant was held", lock_idx);
`endif

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// Testbench for l2_rr_arbiter: a 4-port and a 3-port instance driven in
// lockstep and compared every cycle against a behavioural reference model.
module tb_l2_rr_arbiter;
    import l2_config_and_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_rr_arbiter_if #(.NUM_PORTS(4)) bus4 ();
    l2_rr_arbiter_if #(.NUM_PORTS(3)) bus3 ();

    l2_rr_arbiter #(.NUM_PORTS(4)) dut4 (.clk(clk), .rst(rst), .arb(bus4.slave));
    l2_rr_arbiter #(.NUM_PORTS(3)) dut3 (.clk(clk), .rst(rst), .arb(bus3.slave));

    int errors = 0;
    int checks = 0;

    // Reference model: index 0 = 4-port instance, index 1 = 3-port instance.
    int nports [2] = '{4, 3};
    int m_locked [2];
    int m_last [2];
    int m_lock [2];

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_locked[d] = 0;
            m_last[d]   = nports[d] - 1;
            m_lock[d]   = 0;
        end
    endfunction

    // Expected outputs: a held grant shows the held port; otherwise scan the
    // ports in rotation order starting just after the last accepted one.
    function automatic void model_out(input int d, input logic [3:0] req,
                                      output int v, output int idx, output int vec);
        v = 0; idx = 0; vec = 0;
        if (m_locked[d] != 0) begin
            idx = m_lock[d];
            v   = int'(req[idx]);
            vec = 1 << idx;
        end else begin
            for (int k = 1; k <= nports[d]; k++) begin
                int p;
                p = (m_last[d] + k) % nports[d];
                if (req[p]) begin
                    v = 1; idx = p; vec = 1 << p;
                    break;
                end
            end
        end
    endfunction

    function automatic void model_step(input int d, input logic [3:0] req, input logic stb);
        int v, idx, vec;
        model_out(d, req, v, idx, vec);
        if (m_locked[d] != 0) begin
            if (!req[m_lock[d]]) begin
                m_locked[d] = 0;
            end else if (stb) begin
                m_last[d]   = m_lock[d];
                m_locked[d] = 0;
            end
        end else if (v != 0) begin
            if (stb) m_last[d] = idx;
            else begin
                m_lock[d]   = idx;
                m_locked[d] = 1;
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        int v, idx, vec;
        model_out(0, bus4.requests, v, idx, vec);
        check_eq({tag, " p4 valid"}, 32'(bus4.grantee_valid), 32'(v));
        check_eq({tag, " p4 idx"},   32'(bus4.grantee_i),     32'(idx));
        check_eq({tag, " p4 vec"},   32'(bus4.grantee_v),     32'(vec));
        model_out(1, {1'b0, bus3.requests}, v, idx, vec);
        check_eq({tag, " p3 valid"}, 32'(bus3.grantee_valid), 32'(v));
        check_eq({tag, " p3 idx"},   32'(bus3.grantee_i),     32'(idx));
        check_eq({tag, " p3 vec"},   32'(bus3.grantee_v),     32'(vec));
        check_eq({tag, " p3 idx range"}, 32'(bus3.grantee_i < 2'd3), 32'd1);
    endtask

    task automatic tick(input logic [3:0] r4, input logic s4,
                        input logic [2:0] r3, input logic s3, input string tag);
        @(negedge clk);
        bus4.requests = r4; bus4.strobe = s4;
        bus3.requests = r3; bus3.strobe = s3;
        #1;
        compare_all(tag);
        @(posedge clk);
        if (!rst) begin
            model_step(0, r4, s4);
            model_step(1, {1'b0, r3}, s3);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus4.requests = '0; bus4.strobe = 1'b0;
        bus3.requests = '0; bus3.strobe = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("in reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus4.requests = '0; bus4.strobe = 1'b0;
        bus3.requests = '0; bus3.strobe = 1'b0;
        model_reset();
        apply_reset();

        // Idle with nothing requesting, then rotation from port 0.
        tick(4'b0000, 1'b0, 3'b000, 1'b0, "idle");
        tick(4'b1010, 1'b1, 3'b000, 1'b0, "1010 first");
        check_eq("1010 first literal", 32'(bus4.grantee_i), 32'd1);
        tick(4'b1010, 1'b1, 3'b000, 1'b0, "1010 second");
        check_eq("1010 second literal", 32'(bus4.grantee_i), 32'd3);

        // Full rotation on both instances.
        for (int c = 0; c < 8; c++) begin
            tick(4'b1111, 1'b1, 3'b111, 1'b1, "all requesting");
            check_eq("rotation p4", 32'(bus4.grantee_i), 32'(c % 4));
        end

        // Hold on port 2 despite a higher-priority newcomer, then accept.
        apply_reset();
        for (int c = 0; c < 3; c++) tick(4'b0100, 1'b0, 3'b100, 1'b0, "hold");
        tick(4'b0101, 1'b0, 3'b101, 1'b0, "hold vs newcomer");
        check_eq("held port", 32'(bus4.grantee_i), 32'd2);
        tick(4'b0101, 1'b1, 3'b101, 1'b1, "accept held");
        tick(4'b0101, 1'b0, 3'b101, 1'b0, "after accept");
        check_eq("after accept literal", 32'(bus4.grantee_i), 32'd0);

        // Requester withdraws while held.
        apply_reset();
        tick(4'b0100, 1'b0, 3'b100, 1'b0, "lock for withdraw");
        tick(4'b0001, 1'b1, 3'b001, 1'b1, "withdraw");
        check_eq("withdraw valid", 32'(bus4.grantee_valid), 32'd0);
        tick(4'b0001, 1'b1, 3'b001, 1'b1, "after withdraw");
        check_eq("after withdraw literal", 32'(bus4.grantee_i), 32'd0);

        // Asynchronous reset in the middle of a held grant.
        apply_reset();
        tick(4'b1000, 1'b0, 3'b100, 1'b0, "lock on 3");
        tick(4'b1001, 1'b0, 3'b101, 1'b0, "still locked");
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("async reset");
        check_eq("async reset literal", 32'(bus4.grantee_i), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(4'b1001, 1'b1, 3'b101, 1'b1, "after reset release");
        check_eq("after reset literal", 32'(bus4.grantee_i), 32'd0);

        // Randomised traffic; held requesters mostly keep requesting.
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            logic [3:0] r4;
            logic [2:0] r3;
            r4 = 4'($urandom);
            r3 = 3'($urandom);
            if (m_locked[0] != 0 && $urandom_range(0, 9) != 0) r4[m_lock[0]] = 1'b1;
            if (m_locked[1] != 0 && $urandom_range(0, 9) != 0) r3[m_lock[1]] = 1'b1;
            tick(r4, $urandom_range(0, 2) != 0, r3, $urandom_range(0, 2) != 0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_rr_arbiter.md
Name: l2_rr_arbiter

Overview:
- Slave-side implementation of the L2 arbitration interface: the arbiter that answers the request vector and strobe driven by the L2 front-end (master side).
- Selects one requesting port by round-robin and presents it as an index (grantee_i), a one-hot vector (grantee_v) and a valid flag (grantee_valid).
- Holds a presented grant stable until the master strobes acceptance.
- Sits between the per-port L2 request queues and the L2 request mux.

Parameters:
- NUM_PORTS, L2_NUM_PORTS, number of requesting ports; must be >= 2; non-power-of-two allowed.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset, asynchronous, active-high.
- requests  input  NUM_PORTS  per-port request; bit k = port k.
- strobe  input  1  master accepts the currently presented grant this cycle.
- grantee_i  output  $clog2(NUM_PORTS)  granted port index.
- grantee_v  output  NUM_PORTS  one-hot granted port.
- grantee_valid  output  1  grantee_i / grantee_v are meaningful.

Interface note:
- One clock; reset is asynchronous and active-high.

Behaviour:
- State:
  - state in {ARB_IDLE, ARB_LOCKED}.
  - last_ptr: index of the last accepted grantee.
  - lock_idx: index of the held grantee.
- Reset: state=ARB_IDLE, last_ptr=NUM_PORTS-1 (port 0 is highest priority after reset), lock_idx=0.
- Outputs are combinational from state and requests. Consequently, with requests=0: grantee_valid=0, grantee_v=0, grantee_i=0, including during and right after reset.
- Round-robin pick: the first set bit of requests searching (last_ptr+1) mod NUM_PORTS upward with wrap. The search must wrap correctly for non-power-of-two NUM_PORTS; indices never exceed NUM_PORTS-1.
- ARB_IDLE:
  - grantee_valid = |requests; grantee_i = pick; grantee_v = one-hot(pick). Zero-cycle latency from request to grant.
  - valid & strobe: last_ptr<=pick; stay ARB_IDLE.
  - valid & !strobe: lock_idx<=pick; go ARB_LOCKED.
  - !valid: no state change. A strobe while !valid is ignored.
- ARB_LOCKED:
  - grantee_i = lock_idx; grantee_v = one-hot(lock_idx); grantee_valid = requests[lock_idx].
  - Requests from other ports, including ones of higher priority, never change the grant.
  - requests[lock_idx] & strobe: last_ptr<=lock_idx; go ARB_IDLE. The next grant may be presented in the following cycle.
  - requests[lock_idx]=0 (protocol violation: requester withdrew): grantee_valid=0 this cycle; go ARB_IDLE; last_ptr unchanged; any strobe ignored. Simulation-only assertion fires.
  - Otherwise stay ARB_LOCKED.
- Outputs are always consistent: grantee_v == one-hot(grantee_i) whenever grantee_valid=1.
- Reset asserted mid-lock: returns immediately (asynchronously) to ARB_IDLE, last_ptr=NUM_PORTS-1; the pending grant is lost.
- Fairness: with all ports requesting continuously and strobe every cycle, grants rotate 0,1,…,NUM_PORTS-1,0,…. No port waits more than NUM_PORTS-1 accepted grants.
- Assertions (simulation only):
  - $onehot0(grantee_v).
  - grantee_valid implies requests[grantee_i].
  - Stability: in ARB_LOCKED without strobe, grantee_i is unchanged from the previous cycle.

Decomposition:
- Shared package l2_config_and_types: add typedef enum arb_state_t {ARB_IDLE, ARB_LOCKED}. L2_NUM_PORTS remains there.
- Sub-module l2_rr_picker: purely combinational. Inputs: requests, last_ptr. Outputs: pick_idx, pick_onehot, any. Implemented as a double-width masked priority encode.
- The top module owns the state register, last_ptr, lock_idx and output muxing, and connects to the interface via its slave modport.

Test Plan (NUM_PORTS=4 unless stated):
- Reset then requests=4'b0000 -> grantee_valid=0, grantee_v=0, grantee_i=0. Then requests=4'b1010 with strobe=1 -> same cycle grantee_i=1, grantee_v=4'b0010; next cycle with requests=4'b1010 -> grantee_i=3.
- requests=4'b1111, strobe=1 every cycle for 8 cycles -> grantee_i sequence 0,1,2,3,0,1,2,3.
- requests=4'b0100, strobe=0 for 3 cycles, then requests=4'b0101 -> grant held at grantee_i=2 (ARB_LOCKED). Strobe -> next cycle grantee_i=0.
- In ARB_LOCKED on port 2, drop requests[2] with requests=4'b0001 -> that cycle grantee_valid=0; next cycle ARB_IDLE, grantee_i=0 with last_ptr unchanged (port 0 wins because search starts at 0 after reset).
- Assert rst asynchronously mid-lock on port 3 -> outputs follow the idle pick immediately; after release with requests=4'b1001 -> grantee_i=0.
- NUM_PORTS=3, requests=3'b111, strobe every cycle -> sequence 0,1,2,0; grantee_i never equals 3.
